// File: rtl/cci_mpf_shim_pkg.sv
// Shared definitions for the shim mdata tagging scheme.
//
// Shim-generated requests mark their mdata with a reserved bit plus a small
// tag in mdata[1:0] that names the owning shim. The response side uses the
// test helper to decide which responses belong to an instance.
package cci_mpf_shim_pkg;

    // Tag identifying which shim engine issued a request.
    typedef enum logic [1:0] {
        CCI_MPF_SHIM_TAG_VTP    = 2'd0,
        CCI_MPF_SHIM_TAG_PWRITE = 2'd1
    } t_cci_mpf_shim_tag;

    // Mark mdata as shim-owned: set the reserved bit and write the tag.
    function automatic logic [15:0] cci_mpf_setShimMdataTag(
        input logic [3:0]        idx,
        input t_cci_mpf_shim_tag tag,
        input logic [15:0]       mdata
    );
        logic [15:0] m;
        m      = mdata;
        m[idx] = 1'b1;
        m[1:0] = tag;
        return m;
    endfunction

    // True when mdata carries the reserved bit and exactly this tag.
    function automatic logic cci_mpf_testShimMdataTag(
        input logic [3:0]        idx,
        input t_cci_mpf_shim_tag tag,
        input logic [15:0]       mdata
    );
        return mdata[idx] && (mdata[1:0] == tag);
    endfunction

endpackage

// File: rtl/cci_mpf_shim_rsp_fifo.sv
// Show-ahead capture FIFO for shim-owned responses.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   wr_en, wr_data    push request; ignored when full unless rd_en pops
//   rd_en             pop the head; ignored when empty
//   rd_data           current head entry (valid whenever !empty)
//   full, empty       occupancy flags
//   count             number of stored entries, 0..DEPTH
module cci_mpf_shim_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 528
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A write into a full FIFO is legal only when the head leaves in the
    // same cycle; the freed slot is the one wr_ptr already points at.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/cci_mpf_shim_rsp_steer.sv
// Response steering for one shim instance.
//
// Every read response from the FIU side is either claimed (reserved bit set
// and tag == SHIM_TAG) into a capture FIFO for the shim's internal engine,
// or forwarded toward the AFU through a one-cycle register. A credit counter
// bounds outstanding internal requests to DEPTH so the FIFO never overruns.
//
// Handshakes: rsp_in_valid and fwd_rsp_valid carry no backpressure (a beat
// is transferred whenever valid is high). shim_rsp_valid/shim_rsp_ready is
// strict valid/ready: the head transfers in a cycle where both are high,
// and valid never depends on ready.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   rsp_in_valid/mdata/data          incoming response
//   fwd_rsp_valid/mdata/data         registered non-claimed response
//   shim_req_credit                  engine may issue a request this cycle
//   shim_req_issue                   engine issued a tagged request
//   shim_rsp_valid/ready/mdata/data  captured-response FIFO head
//   err_unexpected                   sticky protocol error
module cci_mpf_shim_rsp_steer
    import cci_mpf_shim_pkg::*;
#(
    parameter int                RESERVED_IDX = 15,
    parameter t_cci_mpf_shim_tag SHIM_TAG     = CCI_MPF_SHIM_TAG_VTP,
    parameter int                DEPTH        = 4,
    parameter int                DATA_WIDTH   = 512
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rsp_in_valid,
    input  logic [15:0]           rsp_in_mdata,
    input  logic [DATA_WIDTH-1:0] rsp_in_data,
    output logic                  fwd_rsp_valid,
    output logic [15:0]           fwd_rsp_mdata,
    output logic [DATA_WIDTH-1:0] fwd_rsp_data,
    output logic                  shim_req_credit,
    input  logic                  shim_req_issue,
    output logic                  shim_rsp_valid,
    input  logic                  shim_rsp_ready,
    output logic [15:0]           shim_rsp_mdata,
    output logic [DATA_WIDTH-1:0] shim_rsp_data,
    output logic                  err_unexpected
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = 16 + DATA_WIDTH;

    logic                  match;
    logic                  pop;
    logic                  issue_ok;
    logic                  dec_ok;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [FW-1:0]         fifo_head;
    logic [CW-1:0]         outstanding;

    assign match = rsp_in_valid &&
                   cci_mpf_testShimMdataTag(4'(RESERVED_IDX), SHIM_TAG, rsp_in_mdata);

    assign shim_rsp_valid  = !fifo_empty;
    assign pop             = shim_rsp_valid && shim_rsp_ready;
    assign shim_req_credit = (outstanding < CW'(DEPTH));
    assign issue_ok        = shim_req_issue && shim_req_credit;
    // A captured response with no matching request (already flagged) must
    // not drive the counter below zero when it is popped.
    assign dec_ok          = pop && (outstanding != '0);

    assign shim_rsp_mdata = fifo_head[FW-1 -: 16];
    assign shim_rsp_data  = fifo_head[DATA_WIDTH-1:0];

    cci_mpf_shim_rsp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (match),
        .wr_data ({rsp_in_mdata, rsp_in_data}),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Forward register; payload holds its last value when nothing forwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd_rsp_valid <= 1'b0;
            fwd_rsp_mdata <= '0;
            fwd_rsp_data  <= '0;
        end else begin
            fwd_rsp_valid <= rsp_in_valid && !match;
            if (rsp_in_valid && !match) begin
                fwd_rsp_mdata <= rsp_in_mdata;
                fwd_rsp_data  <= rsp_in_data;
            end
        end
    end

    // Outstanding-request counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else begin
            case ({issue_ok, dec_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Sticky error: issue without credit, response with no request pending
    // (every outstanding request already has its answer in the FIFO), or a
    // response dropped because the FIFO is full and not popping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_unexpected <= 1'b0;
        end else if ((shim_req_issue && !shim_req_credit) ||
                     (match && (fifo_count == outstanding)) ||
                     (match && fifo_full && !pop)) begin
            err_unexpected <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cci_mpf_shim_rsp_steer.sv
module tb_cci_mpf_shim_rsp_steer;
    import cci_mpf_shim_pkg::*;

    localparam int DW = 512;
    localparam int EW = 16 + DW;

    logic          clk;
    logic          reset_n;
    logic          rsp_in_valid;
    logic [15:0]   rsp_in_mdata;
    logic [DW-1:0] rsp_in_data;
    logic          fwd_rsp_valid;
    logic [15:0]   fwd_rsp_mdata;
    logic [DW-1:0] fwd_rsp_data;
    logic          shim_req_credit;
    logic          shim_req_issue;
    logic          shim_rsp_valid;
    logic          shim_rsp_ready;
    logic [15:0]   shim_rsp_mdata;
    logic [DW-1:0] shim_rsp_data;
    logic          err_unexpected;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [EW-1:0] exp_q[$];

    typedef struct {
        logic [15:0] mdata;
        logic [31:0] data;
    } fwd_vec_t;

    cci_mpf_shim_rsp_steer #(
        .RESERVED_IDX (15),
        .SHIM_TAG     (CCI_MPF_SHIM_TAG_VTP),
        .DEPTH        (4),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rsp_in_valid    (rsp_in_valid),
        .rsp_in_mdata    (rsp_in_mdata),
        .rsp_in_data     (rsp_in_data),
        .fwd_rsp_valid   (fwd_rsp_valid),
        .fwd_rsp_mdata   (fwd_rsp_mdata),
        .fwd_rsp_data    (fwd_rsp_data),
        .shim_req_credit (shim_req_credit),
        .shim_req_issue  (shim_req_issue),
        .shim_rsp_valid  (shim_rsp_valid),
        .shim_rsp_ready  (shim_rsp_ready),
        .shim_rsp_mdata  (shim_rsp_mdata),
        .shim_rsp_data   (shim_rsp_data),
        .err_unexpected  (err_unexpected)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checker
    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rsp_in_valid   = 1'b0;
        rsp_in_mdata   = '0;
        rsp_in_data    = '0;
        shim_req_issue = 1'b0;
        shim_rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        exp_q.delete();
    endtask

    // One cycle with optional response, issue and ready.
    task automatic cycle(input logic v, input logic [15:0] md, input logic [31:0] d,
                         input logic issue, input logic rdy);
        rsp_in_valid   = v;
        rsp_in_mdata   = md;
        rsp_in_data    = '0;
        rsp_in_data[31:0] = d;
        shim_req_issue = issue;
        shim_rsp_ready = rdy;
        tick();
        idle_inputs();
    endtask

    task automatic issue_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
    endtask

    // Tagged (claimed) response; scoreboard records it.
    task automatic send_tagged(input logic [31:0] d, input logic issue, input logic rdy);
        logic [DW-1:0] dd;
        logic [15:0]   md;
        md = cci_mpf_setShimMdataTag(4'd15, CCI_MPF_SHIM_TAG_VTP, 16'h0000);
        dd = '0;
        dd[31:0] = d;
        exp_q.push_back({md, dd});
        cycle(1'b1, md, d, issue, rdy);
    endtask

    // Pop the head and compare it against the scoreboard.
    task automatic pop_check(input string name);
        logic [EW-1:0] e;
        check({name, "_valid"}, EW'(shim_rsp_valid), EW'(1));
        if (exp_q.size() == 0) begin
            check({name, "_queue"}, EW'(exp_q.size()), EW'(1));
        end else begin
            e = exp_q.pop_front();
            check({name, "_head"}, {shim_rsp_mdata, shim_rsp_data}, e);
        end
        cycle(1'b0, 16'h0, 32'h0, 1'b0, 1'b1);
    endtask

    fwd_vec_t fwd_tbl[7];

    initial begin
        fwd_tbl[0] = '{16'h0012, 32'h0000_0012};  // plain AFU traffic
        fwd_tbl[1] = '{16'h8001, 32'hDEAD_BEEF};  // reserved bit, PWRITE tag
        fwd_tbl[2] = '{16'h0000, 32'h1111_2222};  // tag bits match, no reserved bit
        fwd_tbl[3] = '{16'h7FFC, 32'h3333_4444};  // all but reserved bit
        fwd_tbl[4] = '{16'h8002, 32'h5555_6666};  // reserved bit, unused tag 2
        fwd_tbl[5] = '{16'h8003, 32'h7777_8888};  // reserved bit, unused tag 3
        fwd_tbl[6] = '{16'hFFFD, 32'h9999_AAAA};  // reserved bit, PWRITE tag

        reset_n = 1'b1;
        idle_inputs();
        #2;
        reset_n = 1'b0;
        #3;
        check("rst_fwd_valid", EW'(fwd_rsp_valid), EW'(0));
        check("rst_shim_valid", EW'(shim_rsp_valid), EW'(0));
        check("rst_err", EW'(err_unexpected), EW'(0));
        check("rst_credit", EW'(shim_req_credit), EW'(1));
        do_reset();

        // Forward table: each vector forwarded next cycle, nothing captured.
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, fwd_tbl[i].mdata, fwd_tbl[i].data, 1'b0, 1'b0);
            check($sformatf("fwd%0d_valid", i), EW'(fwd_rsp_valid), EW'(1));
            check($sformatf("fwd%0d_mdata", i), EW'(fwd_rsp_mdata), EW'(fwd_tbl[i].mdata));
            check($sformatf("fwd%0d_data", i), EW'(fwd_rsp_data), EW'(fwd_tbl[i].data));
            check($sformatf("fwd%0d_shim_valid", i), EW'(shim_rsp_valid), EW'(0));
        end
        cycle(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
        check("fwd_idle_valid", EW'(fwd_rsp_valid), EW'(0));
        check("fwd_idle_hold", EW'(fwd_rsp_mdata), EW'(16'hFFFD));
        check("fwd_err", EW'(err_unexpected), EW'(0));

        // Claim: one request then its response.
        issue_n(1);
        check("claim_out1", EW'(dut.outstanding), EW'(1));
        send_tagged(32'hA5, 1'b0, 1'b0);
        check("claim_fwd_valid", EW'(fwd_rsp_valid), EW'(0));
        check("claim_data", EW'(shim_rsp_data), EW'(32'hA5));
        pop_check("claim_pop");
        check("claim_out0", EW'(dut.outstanding), EW'(0));
        check("claim_empty", EW'(shim_rsp_valid), EW'(0));
        check("claim_err", EW'(err_unexpected), EW'(0));

        // Credit exhaustion.
        issue_n(4);
        check("cred_credit0", EW'(shim_req_credit), EW'(0));
        check("cred_err0", EW'(err_unexpected), EW'(0));
        issue_n(1);
        check("cred_err1", EW'(err_unexpected), EW'(1));
        check("cred_out4", EW'(dut.outstanding), EW'(4));
        for (int i = 1; i <= 4; i++) send_tagged(32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pop_check($sformatf("cred_pop%0d", i));
        check("cred_credit1", EW'(shim_req_credit), EW'(1));
        check("cred_out0", EW'(dut.outstanding), EW'(0));

        // Simultaneous write, pop and issue with three entries stored.
        do_reset();
        issue_n(3);
        for (int i = 0; i < 3; i++) send_tagged(32'h20 + 32'(i), 1'b0, 1'b0);
        check("sim_count3", EW'(dut.fifo_count), EW'(3));
        check("sim_err0", EW'(err_unexpected), EW'(0));
        begin
            logic [EW-1:0] e;
            e = exp_q[0];
            check("sim_head", {shim_rsp_mdata, shim_rsp_data}, e);
            void'(exp_q.pop_front());
        end
        send_tagged(32'h23, 1'b1, 1'b1);
        check("sim_count", EW'(dut.fifo_count), EW'(3));
        check("sim_out", EW'(dut.outstanding), EW'(3));
        // Every outstanding request was already answered, so this is flagged.
        check("sim_err1", EW'(err_unexpected), EW'(1));
        for (int i = 0; i < 3; i++) pop_check($sformatf("sim_pop%0d", i));
        check("sim_out0", EW'(dut.outstanding), EW'(0));

        // Unexpected response, then asynchronous reset mid-stream.
        do_reset();
        check("unx_err0", EW'(err_unexpected), EW'(0));
        send_tagged(32'h77, 1'b0, 1'b0);
        check("unx_err1", EW'(err_unexpected), EW'(1));
        check("unx_written", EW'(shim_rsp_valid), EW'(1));
        cycle(1'b1, 16'h0012, 32'h12, 1'b1, 1'b0);
        check("unx_fwd_valid", EW'(fwd_rsp_valid), EW'(1));
        check("unx_credit_out", EW'(dut.outstanding), EW'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_fwd_valid", EW'(fwd_rsp_valid), EW'(0));
        check("arst_shim_valid", EW'(shim_rsp_valid), EW'(0));
        check("arst_err", EW'(err_unexpected), EW'(0));
        check("arst_out", EW'(dut.outstanding), EW'(0));
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        tick();
        check("post_credit", EW'(shim_req_credit), EW'(1));
        check("post_shim_valid", EW'(shim_rsp_valid), EW'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
